// File: rtl/day3_adder_pkg.sv
// Shared constants and types for the pipelined wide-word adder.
package day3_adder_pkg;

  localparam int ADD_WIDTH = 100;
  localparam int ADD_SEG   = 25;
  localparam int ADD_NSEG  = ADD_WIDTH / ADD_SEG;

  typedef logic [ADD_WIDTH-1:0] add_word_t;

endpackage

// File: rtl/adder_segment.sv
// Purely combinational SEG-bit adder slice; one of these sits in every
// pipeline stage of the wide adder.
module adder_segment #(
  parameter int SEG = 25
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  // Widen every operand by one bit so the carry-out falls out of the add.
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/day3_100bit_adder.sv
// Pipelined WIDTH-bit adder. The carry chain is cut into NSEG segments of
// SEG bits; each segment adds in its own stage and hands its carry to the
// next stage through a register. The already-finished low partial sums and
// the not-yet-consumed high operand bits ride along with the data, so one
// operand set enters and one result leaves on every clock.
module day3_100bit_adder
  import day3_adder_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH,
  parameter int SEG   = ADD_SEG,
  parameter int NSEG  = WIDTH / SEG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  // The segmented structure only makes sense when segments tile the word
  // exactly and there is more than one of them.
  if (((WIDTH % SEG) != 0) || (NSEG != WIDTH / SEG) || (NSEG < 2)) begin : g_param_check
    $error("day3_100bit_adder: WIDTH must be a multiple of SEG with at least two segments");
  end

  logic [NSEG-1:0] vld_q;

  for (genvar k = 0; k < NSEG; k++) begin : stg
    // Operand bits still waiting to be added when they reach this stage.
    localparam int INW = WIDTH - k * SEG;
    // Number of result bits known once this stage has added.
    localparam int SW  = (k + 1) * SEG;

    logic [INW-1:0] a_in;
    logic [INW-1:0] b_in;
    logic           ci_seg;
    logic [SEG-1:0] s_seg;
    logic           co_seg;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    logic           c_q;

    if (k == 0) begin : g_in
      assign a_in   = A;
      assign b_in   = B;
      assign ci_seg = Cin;
      assign sum_d  = s_seg;
    end else begin : g_in
      assign a_in   = stg[k-1].g_ops.a_q;
      assign b_in   = stg[k-1].g_ops.b_q;
      assign ci_seg = stg[k-1].c_q;
      assign sum_d  = {s_seg, stg[k-1].sum_q};
    end

    adder_segment #(
      .SEG (SEG)
    ) u_seg (
      .a  (a_in[SEG-1:0]),
      .b  (b_in[SEG-1:0]),
      .ci (ci_seg),
      .s  (s_seg),
      .co (co_seg)
    );

    // Capture this segment's sum on top of the lower partial sums, plus its carry.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else begin
        sum_q <= sum_d;
        c_q   <= co_seg;
      end
    end

    if (k < NSEG - 1) begin : g_ops
      logic [INW-SEG-1:0] a_q;
      logic [INW-SEG-1:0] b_q;

      // Delay the unused upper operand bits so they meet their carry next stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_in[INW-1:SEG];
          b_q <= b_in[INW-1:SEG];
        end
      end
    end
  end

  // Shift in_valid alongside the data so it emerges with its own result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[NSEG-2:0], in_valid};
    end
  end

  assign Sum       = stg[NSEG-1].sum_q;
  assign Cout      = stg[NSEG-1].c_q;
  assign out_valid = vld_q[NSEG-1];

endmodule

// File: tb/tb_day3_100bit_adder.sv
// Self-checking bench for the pipelined wide adder: every cycle the outputs
// are compared against a plain-arithmetic model whose results are queued
// NSEG deep to account for the pipeline latency.
module tb_day3_100bit_adder;
  import day3_adder_pkg::*;

  localparam int W = ADD_WIDTH;
  localparam int N = ADD_NSEG;

  logic      clk = 1'b0;
  logic      rst_n;
  add_word_t a_in;
  add_word_t b_in;
  logic      cin;
  logic      vin;
  add_word_t sum;
  logic      cout;
  logic      vout;

  int checks = 0;
  int errors = 0;

  // Each entry is {out_valid, Cout, Sum} expected after one more clock edge.
  logic [W+1:0] exp_q[$];

  always #5 clk = ~clk;

  day3_100bit_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (a_in),
    .B         (b_in),
    .Cin       (cin),
    .in_valid  (vin),
    .Sum       (sum),
    .Cout      (cout),
    .out_valid (vout)
  );

  function automatic logic [W+1:0] model(add_word_t a, add_word_t b, logic c, logic v);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    return {v, full};
  endfunction

  function automatic add_word_t randWord();
    return {4'($urandom()), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic checkOutput(string tag, logic [W+1:0] exp);
    checks++;
    assert (vout === exp[W+1]) else begin
      errors++;
      $error("FAIL %s out_valid: observed %b expected %b", tag, vout, exp[W+1]);
    end
    checks++;
    assert (cout === exp[W]) else begin
      errors++;
      $error("FAIL %s Cout: observed %b expected %b", tag, cout, exp[W]);
    end
    checks++;
    assert (sum === exp[W-1:0]) else begin
      errors++;
      $error("FAIL %s Sum: observed %h expected %h", tag, sum, exp[W-1:0]);
    end
  endtask

  // Reset empties the pipeline, so the first N-1 edges show cleared outputs.
  task automatic primeModel();
    exp_q.delete();
    repeat (N - 1) exp_q.push_back('0);
  endtask

  task automatic applyStimulus(string tag, add_word_t a, add_word_t b, logic c, logic v);
    a_in = a;
    b_in = b;
    cin  = c;
    vin  = v;
    exp_q.push_back(model(a, b, c, v));
    @(posedge clk);
    #1;
    checkOutput(tag, exp_q.pop_front());
  endtask

  initial begin
    add_word_t ones;
    add_word_t one;
    ones  = '1;
    one   = add_word_t'(1);
    rst_n = 1'b0;
    a_in  = '0;
    b_in  = '0;
    cin   = 1'b0;
    vin   = 1'b0;

    #3;
    checkOutput("reset_state", '0);
    #4;
    rst_n = 1'b1;
    primeModel();

    applyStimulus("full_carry_chain", ones, '0, 1'b1, 1'b1);
    applyStimulus("boundary_25", (one << 25) - one, one, 1'b0, 1'b1);
    applyStimulus("boundary_50", (one << 50) - one, one, 1'b0, 1'b1);
    applyStimulus("boundary_75", (one << 75) - one, one, 1'b0, 1'b1);
    applyStimulus("max_operands", ones, ones, 1'b1, 1'b1);
    repeat (N) applyStimulus("drain_directed", '0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      applyStimulus($sformatf("random_%0d", i), randWord(), randWord(), 1'($urandom()), 1'b1);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("valid_alt_%0d", i), randWord(), randWord(), 1'($urandom()), 1'((i + 1) % 2));
    end

    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("pre_reset_%0d", i), randWord(), randWord(), 1'($urandom()), 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_midflight", '0);
    #2;
    vin   = 1'b0;
    rst_n = 1'b1;
    primeModel();

    applyStimulus("post_reset_idle", randWord(), randWord(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus($sformatf("post_reset_%0d", i), randWord(), randWord(), 1'($urandom()), 1'b1);
    end
    repeat (N) applyStimulus("final_drain", '0, '0, 1'b0, 1'b0);

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
